// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES core arbiter.
package aes_pkg;
  localparam int AES_WIDTH       = 128;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module aes_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    // Walk downward so the lowest set offset (closest to ptr) wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx       = sum[IW-1:0];
    any_valid = |req;
    gnt       = any_valid ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core among NUM_REQ requesters: round-robin admit, start/wait
// sequencing with a done watchdog, and response return over valid/ready.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = AES_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [WIDTH-1:0]           rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       core_start_o,
  output logic [WIDTH-1:0]           core_data_o,
  input  logic [WIDTH-1:0]           core_data_i,
  input  logic                       core_done_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_t        state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              done_hit, to_hit;
  logic [WIDTH-1:0]  req_slice [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign req_slice[k] = req_data_i[k*WIDTH +: WIDTH];
  end

  aes_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req       (req_valid_i),
    .ptr       (ptr),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Ready is gated by reset so no handshake can be signalled while held in reset.
  assign req_ready_o = (state == IDLE && rst_n_i) ? pick_gnt : '0;
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_hit  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE:  if (pick_any) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (core_done_i) begin
          done_hit  = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:  if (rsp_ready_i[grant_id_o]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      grant_id_o   <= '0;
      core_data_o  <= '0;
      rsp_data_o   <= '0;
      rsp_err_o    <= 1'b0;
      rsp_valid_o  <= '0;
      core_start_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      core_start_o <= (state_nxt == ISSUE);
      if (state == IDLE && pick_any) begin
        core_data_o <= req_slice[pick_idx];
        grant_id_o  <= pick_idx;
        ptr         <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
      end
      cnt <= (state == WAIT && state_nxt == WAIT) ? cnt + CW'(1) : '0;
      if (done_hit) begin
        rsp_data_o <= core_data_i;
        rsp_err_o  <= 1'b0;
      end else if (to_hit) begin
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
      end
      rsp_valid_o <= (state_nxt == RESP) ? (NUM_REQ'(1) << grant_id_o) : '0;
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench: directed vector table, reset/stale corners, then random traffic vs. a model.
module tb_aes_core_arbiter;
  localparam int N = 4;
  localparam int W = 128;
  localparam int TO = 64;
  localparam int DONE_LAT = 10;
  localparam logic [W-1:0] FIXED_PT  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [W-1:0] FIXED_EXP = 128'hFFEEDDCCBBAA99887766554433221100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0]   rsp_data, core_data_o, core_data_i;
  logic           rsp_err, core_start, core_done, busy;
  logic [1:0]     grant_id;

  aes_core_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .core_start_o(core_start), .core_data_o(core_data_o),
    .core_data_i(core_data_i), .core_done_i(core_done), .busy_o(busy),
    .grant_id_o(grant_id)
  );

  // Core model: done DONE_LAT cycles after start, result = ~plaintext.
  int         age = 0;
  logic [W-1:0] core_q = '0;
  bit         hang_core = 1'b0;
  bit         force_done = 1'b0;
  always @(posedge clk) begin
    if (core_start) begin
      age    <= 1;
      core_q <= ~core_data_o;
    end else if (age > 0 && age < 1000) begin
      age <= age + 1;
    end
  end
  assign core_done   = force_done | (!hang_core && age == DONE_LAT);
  assign core_data_i = core_q;

  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  logic [W-1:0] pt [N];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int model_pick(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string name, input logic [N-1:0] vld, input int exp_g,
                         input int delay, input bit hang, input bit stale, input bit fixed);
    int cyc, starts, exp_lat;
    bit bad_rdy, bad_busy, unstable;
    logic [N-1:0] oh;
    logic [W-1:0] exp_d, hold_d;
    oh = N'(1) << exp_g;
    for (int k = 0; k < N; k++) begin
      pt[k] = fixed ? FIXED_PT : rnd128();
      req_data[k*W +: W] = pt[k];
    end
    hang_core  = hang;
    force_done = stale;
    req_valid  = vld;
    rsp_ready  = '0;
    #1;
    chk({name, " ready"}, W'(req_ready), W'(oh));
    tick();
    cyc = 1; starts = 0; bad_rdy = 0; bad_busy = 0;
    while (rsp_valid == '0 && cyc < 200) begin
      if (core_start) begin
        starts++;
        chk({name, " core_data"}, core_data_o, pt[exp_g]);
      end
      if (req_ready != '0) bad_rdy = 1;
      if (!busy) bad_busy = 1;
      tick();
      cyc++;
    end
    force_done = 1'b0;
    exp_lat = hang ? 2 + TO : (stale ? 3 : 2 + DONE_LAT);
    exp_d   = hang ? '0 : (fixed ? FIXED_EXP : ~pt[exp_g]);
    chk({name, " latency"}, W'(cyc), W'(exp_lat));
    chk({name, " starts"}, W'(starts), W'(1));
    chk({name, " rsp_valid"}, W'(rsp_valid), W'(oh));
    chk({name, " grant_id"}, W'(grant_id), W'(exp_g));
    chk({name, " rsp_err"}, W'(rsp_err), W'(hang));
    chk({name, " rsp_data"}, rsp_data, exp_d);
    chk({name, " busy_noready"}, W'({bad_rdy, bad_busy}), W'(0));
    hold_d = rsp_data;
    unstable = 0;
    rsp_ready = ~oh;  // other requesters' ready must be ignored
    for (int i = 0; i < delay; i++) begin
      tick();
      if (rsp_valid !== oh || rsp_data !== hold_d || rsp_err !== hang) unstable = 1;
      if (req_ready != '0 || core_start) unstable = 1;
    end
    chk({name, " hold"}, W'(unstable), W'(0));
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    chk({name, " after_hs"}, W'({busy, rsp_valid}), W'(0));
    ptr_m = (exp_g + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0] vld;
    int           exp_g;
    int           delay;
    bit           hang;
    bit           stale;
    bit           fixed;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, i % 4, 0, 0, 0, 0};
    tbl[8]  = '{4'b0010, 1, 1,  0, 0, 1};
    tbl[9]  = '{4'b0100, 2, 20, 0, 0, 0};
    tbl[10] = '{4'b1000, 3, 0,  1, 0, 0};
    tbl[11] = '{4'b1001, 0, 0,  0, 0, 0};
    tbl[12] = '{4'b0110, 1, 0,  0, 1, 0};
    tbl[13] = '{4'b0011, 0, 2,  0, 0, 0};
    tbl[14] = '{4'b1010, 1, 0,  0, 0, 0};

    #2;
    chk("reset outs", W'({req_ready, rsp_valid, rsp_err, core_start, busy, grant_id}), W'(0));
    chk("reset rsp_data", rsp_data, '0);
    chk("reset core_data", core_data_o, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].vld, tbl[i].exp_g, tbl[i].delay,
              tbl[i].hang, tbl[i].stale, tbl[i].fixed);

    // Reset at WAIT cycle 5: accept at T, WAIT entered at T+2.
    begin
      bit seen;
      req_valid = 4'b0100;
      #1;
      tick();
      for (int i = 0; i < 6; i++) tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid outs", W'({req_ready, rsp_valid, rsp_err, core_start, busy, grant_id}), W'(0));
      chk("rst_mid data", {rsp_data[63:0], core_data_o[63:0]}, '0);
      tick();
      req_valid = '0;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (rsp_valid != '0 || busy) seen = 1;
      end
      chk("rst_mid no_rsp", W'(seen), W'(0));
      ptr_m = 0;
      run_txn("post_rst", 4'b1111, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] v;
      bit st, hg;
      v  = N'($urandom_range(1, 15));
      st = ($urandom_range(0, 4) == 0);
      hg = !st && ($urandom_range(0, 9) == 0);
      run_txn($sformatf("rnd%0d", i), v, model_pick(v), $urandom_range(0, 3), hg, st, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES-128 round-orchestrator core (start/busy/done interface) between NUM_REQ independent requesters.
- Round-robin arbitration admits one request at a time, then sequences the core: start pulse, wait for done.
- Returns the ciphertext to the granting requester over a valid/ready handshake.
- Provides a done-timeout watchdog so a hung core cannot lock out requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 128, data block width in bits.
- TIMEOUT, 64, maximum cycles in WAIT before the transaction is aborted (>=2).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data_i  input  NUM_REQ*WIDTH  plaintext; slice k = [k*WIDTH +: WIDTH].
- rsp_valid_o  output  NUM_REQ  one-hot response valid to the owning requester.
- rsp_ready_i  input  NUM_REQ  per-requester response ready.
- rsp_data_o  output  WIDTH  shared response bus (ciphertext).
- rsp_err_o  output  1  response is a timeout abort; qualified by rsp_valid_o.
- core_start_o  output  1  one-cycle start pulse to the core.
- core_data_o  output  WIDTH  plaintext to the core; held stable from ISSUE until WAIT exits.
- core_data_i  input  WIDTH  core final output (data_final).
- core_done_i  input  1  core done; pulse or level accepted.
- busy_o  output  1  high whenever state != IDLE.
- grant_id_o  output  $clog2(NUM_REQ)  index of the current or last owner.

Behaviour:
- Reset (async, rst_n_i=0) clears the following:
  - state=IDLE; ptr=0; timeout counter=0.
  - grant_id_o=0; core_data_o=0; rsp_data_o=0.
  - All valid, ready and start outputs, rsp_err_o and busy_o =0.
  - Reset mid-transaction abandons it silently; no response is issued. The core is not reset by this block.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = one-hot of the first asserted req_valid_i, searching from index ptr upward and wrapping mod NUM_REQ. This is combinational from req_valid_i and ptr.
  - On handshake (valid&ready) for index g: capture req_data_i slice g into core_data_o, set grant_id_o=g, set ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - No valid requests: stay in IDLE with all ready=0.
- ISSUE: core_start_o=1 for exactly this cycle; go to WAIT. Any core_done_i seen in ISSUE is ignored (stale level from the previous job).
- WAIT:
  - The counter increments each cycle.
  - core_done_i=1: capture core_data_i into rsp_data_o, rsp_err_o=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: rsp_data_o=0, rsp_err_o=1, go to RESP.
  - done and timeout in the same cycle: done wins.
  - The counter clears on WAIT exit.
- RESP:
  - rsp_valid_o[grant_id_o]=1; rsp_data_o and rsp_err_o are held stable.
  - On rsp_ready_i[grant_id_o] go to IDLE, with rsp_valid_o=0 from the next cycle.
  - rsp_ready_i bits of other requesters are ignored.
  - Backpressure is unbounded; no timeout applies in RESP.
- Latency: accept at cycle T, start at T+1, earliest response valid at T+3 (done seen at T+2). A new accept is possible the cycle after the response handshake.
- Fairness: a requester holding valid continuously is served within NUM_REQ transactions.
- req_ready_o is 0 in every state except IDLE. A requester must hold valid and data stable until accepted.
- Output registers: core_start_o, rsp_* and grant_id_o are registered. req_ready_o is combinational.

Decomposition:
- Package aes_pkg holds:
  - AES_WIDTH=128.
  - State enum encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Default TIMEOUT.
- Sub-module aes_rr_pick is purely combinational.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
  - Implementation: double-width rotate then priority encode.

Test Plan:
Bench core model: 10-cycle done latency, core_data_i = ~plaintext.
- Single request: req 1 sends 128'h00112233445566778899AABBCCDDEEFF.
  - Exactly one core_start_o pulse.
  - rsp_valid_o=4'b0010, rsp_data_o=128'hFFEEDDCCBBAA99887766554433221100, rsp_err_o=0.
  - busy_o low the cycle after the response handshake.
- Round robin: all 4 valid continuously, 8 transactions.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each response is routed only to its owner's rsp_valid_o bit.
- Backpressure: rsp_ready_i[2] held low for 20 cycles.
  - rsp_valid_o[2] and rsp_data_o stay stable.
  - req_ready_o=0 throughout; no new core_start_o.
- Timeout: core model never asserts done, TIMEOUT=64.
  - Response appears 64 cycles after WAIT entry with rsp_err_o=1, rsp_data_o=0.
  - The next requester is served normally afterwards.
- Stale done level: core_done_i left high from the previous job.
  - It is ignored in ISSUE and captured only in WAIT.
  - Response data matches the new job.
- Reset mid-WAIT: rst_n_i pulsed low at cycle 5 of WAIT.
  - All outputs are 0 immediately (async); no response is issued.
  - The first grant after reset goes to requester 0.
